// File: rtl/ahb3lite_master_if.sv
// Command/data-strobe side and AHB3-Lite bus side of ahb3lite_master in one bundle.
// The master modport is the initiator's view; the slave modport is the environment's view.
interface ahb3lite_master_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [HADDR_SIZE-1:0] cmd_addr;
  logic [2:0]            cmd_size;
  logic [4:0]            cmd_len;
  logic [HDATA_SIZE-1:0] wr_data;
  logic                  wr_ready;
  logic [HDATA_SIZE-1:0] rd_data;
  logic                  rd_valid;
  logic                  done;
  logic                  err;

  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len, wr_data,
    input  HRDATA, HREADY, HRESP,
    output cmd_ready, wr_ready, rd_data, rd_valid, done, err,
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len, wr_data,
    output HRDATA, HREADY, HRESP,
    input  cmd_ready, wr_ready, rd_data, rd_valid, done, err,
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK
  );
endinterface

// File: rtl/ahb3lite_master.sv
// AHB3-Lite initiator: turns a command/data-strobe request into pipelined AHB3-Lite transfers.
// Define AHB_MASTER_BURST_EN for SEQ bursts with HBURST coding and the 1 KB boundary check.
module ahb3lite_master #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int MAX_BEATS  = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb3lite_master_if.master bus
);
  localparam int MAX_SIZE = $clog2(HDATA_SIZE / 8);

  typedef enum logic [2:0] {S_IDLE, S_NONSEQ, S_SEQ, S_LAST, S_ERR2} state_t;
  typedef enum logic [1:0] {TR_IDLE = 2'b00, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11} htrans_t;
  typedef enum logic [2:0] {
    BU_SINGLE = 3'b000, BU_INCR = 3'b001, BU_INCR4 = 3'b011,
    BU_INCR8  = 3'b101, BU_INCR16 = 3'b111
  } hburst_t;

  state_t                state;
  htrans_t               htrans;
  hburst_t               hburst;
  logic                  hsel;
  logic [HADDR_SIZE-1:0] haddr;
  logic [HDATA_SIZE-1:0] hwdata;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [4:0]            beats_left;
  logic                  dphase;
  logic                  dwrite;
  logic                  cmd_ready_q;
  logic                  rd_valid_q;
  logic [HDATA_SIZE-1:0] rd_data_q;
  logic                  done_q;
  logic                  err_q;

  logic                  size_bad;
  logic                  len_bad;
  logic                  align_bad;
  logic                  reject;
  hburst_t               burst_sel;
  htrans_t               next_trans;
  state_t                next_beat_state;
  logic [HADDR_SIZE-1:0] addr_inc;
  logic                  addr_done;
  logic                  data_err;
`ifdef AHB_MASTER_BURST_EN
  logic [15:0]           span_end;
`endif

  always_comb begin
    size_bad  = bus.cmd_size > 3'(MAX_SIZE);
    len_bad   = (bus.cmd_len == '0) || (32'(bus.cmd_len) > 32'(MAX_BEATS));
    align_bad = |(bus.cmd_addr & ((HADDR_SIZE'(1) << bus.cmd_size) - HADDR_SIZE'(1)));
`ifdef AHB_MASTER_BURST_EN
    span_end  = 16'(bus.cmd_addr[9:0]) + (16'(bus.cmd_len) << bus.cmd_size);
    reject    = size_bad || len_bad || align_bad || (span_end > 16'd1024);
    case (bus.cmd_len)
      5'd1:    burst_sel = BU_SINGLE;
      5'd4:    burst_sel = BU_INCR4;
      5'd8:    burst_sel = BU_INCR8;
      5'd16:   burst_sel = BU_INCR16;
      default: burst_sel = BU_INCR;
    endcase
    next_trans      = TR_SEQ;
    next_beat_state = S_SEQ;
`else
    reject          = size_bad || len_bad || align_bad;
    burst_sel       = BU_SINGLE;
    next_trans      = TR_NONSEQ;
    next_beat_state = S_NONSEQ;
`endif
  end

  assign addr_inc  = HADDR_SIZE'(1) << hsize;
  assign addr_done = htrans[1] && bus.HREADY;
  assign data_err  = dphase && bus.HRESP && !bus.HREADY;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= S_IDLE;
      htrans      <= TR_IDLE;
      hburst      <= BU_SINGLE;
      hsel        <= 1'b0;
      haddr       <= '0;
      hwdata      <= '0;
      hwrite      <= 1'b0;
      hsize       <= '0;
      beats_left  <= '0;
      dphase      <= 1'b0;
      dwrite      <= 1'b0;
      cmd_ready_q <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      // An erroring beat never completes with HRESP low, so it yields no rd_valid.
      if (dphase && !dwrite && bus.HREADY && !bus.HRESP) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= bus.HRDATA;
      end
      if (addr_done && hwrite) hwdata <= bus.wr_data;

      case (state)
        S_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            if (reject) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              state       <= S_NONSEQ;
              htrans      <= TR_NONSEQ;
              hsel        <= 1'b1;
              haddr       <= bus.cmd_addr;
              hwrite      <= bus.cmd_write;
              hsize       <= bus.cmd_size;
              hburst      <= burst_sel;
              beats_left  <= bus.cmd_len - 5'd1;
              cmd_ready_q <= 1'b0;
            end
          end
        end
        S_NONSEQ, S_SEQ: begin
          if (data_err) begin
            state  <= S_ERR2;
            htrans <= TR_IDLE;
            hsel   <= 1'b0;
          end else if (bus.HREADY) begin
            dphase <= 1'b1;
            dwrite <= hwrite;
            if (beats_left == '0) begin
              state  <= S_LAST;
              htrans <= TR_IDLE;
              hsel   <= 1'b0;
            end else begin
              state      <= next_beat_state;
              htrans     <= next_trans;
              haddr      <= haddr + addr_inc;
              beats_left <= beats_left - 5'd1;
            end
          end
        end
        S_LAST: begin
          if (data_err) begin
            state <= S_ERR2;
          end else if (bus.HREADY) begin
            state       <= S_IDLE;
            dphase      <= 1'b0;
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
          end
        end
        S_ERR2: begin
          if (bus.HREADY) begin
            state       <= S_IDLE;
            dphase      <= 1'b0;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // wr_ready must mark exactly the edge an address phase completes, so it is gated by HREADY.
  assign bus.wr_ready  = addr_done && hwrite;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.HSEL      = hsel;
  assign bus.HADDR     = haddr;
  assign bus.HWDATA    = hwdata;
  assign bus.HWRITE    = hwrite;
  assign bus.HSIZE     = hsize;
  assign bus.HBURST    = hburst;
  assign bus.HPROT     = 4'b0011;
  assign bus.HTRANS    = htrans;
  assign bus.HMASTLOCK = 1'b0;
endmodule

// File: tb/tb_ahb3lite_master.sv
// Directed self-checking bench for ahb3lite_master with a small AHB memory slave
// that can insert wait states or a two-cycle ERROR on a chosen beat.
`timescale 1ns/1ps
module tb_ahb3lite_master;
`ifdef AHB_MASTER_BURST_EN
  localparam logic BURST = 1'b1;
`else
  localparam logic BURST = 1'b0;
`endif
  localparam logic [1:0] T_SEQ = BURST ? 2'b11 : 2'b10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ahb3lite_master_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus ();

  ahb3lite_master #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MAX_BEATS(16)) dut (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model
  logic        s_act, s_wr;
  logic [31:0] s_addr;
  int          s_beats, s_wait, s_err;
  int          wait_beat, wait_len, err_beat;
  logic [31:0] mem [0:1023];

  assign bus.HREADY = !s_act ? 1'b1 : (s_err == 1) ? 1'b0 : (s_err == 2) ? 1'b1 : (s_wait == 0);
  assign bus.HRESP  = s_act && (s_err != 0);
  assign bus.HRDATA = (s_act && !s_wr) ? mem[s_addr[11:2]] : 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_act   <= 1'b0;
      s_wr    <= 1'b0;
      s_addr  <= '0;
      s_beats <= 0;
      s_wait  <= 0;
      s_err   <= 0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) s_beats <= 0;
      if (s_act) begin
        if (s_err == 1) s_err <= 2;
        else if (s_err == 2) begin
          s_err <= 0;
          s_act <= 1'b0;
        end else if (s_wait > 0) s_wait <= s_wait - 1;
        else begin
          if (s_wr) mem[s_addr[11:2]] <= bus.HWDATA;
          s_act <= 1'b0;
        end
      end
      if (bus.HREADY && bus.HTRANS[1]) begin
        s_act   <= 1'b1;
        s_wr    <= bus.HWRITE;
        s_addr  <= bus.HADDR;
        s_beats <= s_beats + 1;
        s_wait  <= (s_beats + 1 == wait_beat) ? wait_len : 0;
        s_err   <= (s_beats + 1 == err_beat) ? 1 : 0;
      end
    end
  end

  // Write data source and per-cycle trace of one command
  logic [31:0] wbuf [0:15];
  int          wbeat;
  assign bus.wr_data = wbuf[wbeat[3:0]];

  logic [1:0]  tr_htrans  [0:63];
  logic [31:0] tr_haddr   [0:63];
  logic [31:0] tr_hwdata  [0:63];
  logic [2:0]  tr_hburst  [0:63];
  logic        tr_hready  [0:63];
  logic        tr_hsel    [0:63];
  logic        tr_wrready [0:63];
  logic [31:0] rd_buf     [0:15];
  int          rd_cnt;
  int          lat;
  logic        got_err;

  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [4:0] len);
    int   n;
    logic wr_take;
    lat     = -1;
    got_err = 1'b0;
    rd_cnt  = 0;
    wbeat   = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_size  = size;
    bus.cmd_len   = len;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      tr_htrans[k]  = bus.HTRANS;
      tr_haddr[k]   = bus.HADDR;
      tr_hwdata[k]  = bus.HWDATA;
      tr_hburst[k]  = bus.HBURST;
      tr_hready[k]  = bus.HREADY;
      tr_hsel[k]    = bus.HSEL;
      tr_wrready[k] = bus.wr_ready;
      if (bus.rd_valid && rd_cnt < 16) begin
        rd_buf[rd_cnt] = bus.rd_data;
        rd_cnt++;
      end
      if (bus.done) begin
        lat     = k;
        got_err = bus.err;
        break;
      end
      wr_take = bus.wr_ready;
      @(posedge clk);
      #1;
      if (wr_take) wbeat++;
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_ahbctl"}, {bus.HSEL, bus.HTRANS, bus.HWRITE, bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK},
          {1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 4'b0011, 1'b0});
    check({p, "_haddr"}, bus.HADDR, 32'h0);
    check({p, "_hwdata"}, bus.HWDATA, 32'h0);
    check({p, "_handshake"}, {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.done, bus.err}, 5'b10000);
    check({p, "_rd_data"}, bus.rd_data, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_size  = '0;
    bus.cmd_len   = '0;
    wait_beat = 0;
    wait_len  = 0;
    err_beat  = 0;
    wbeat     = 0;
    for (int i = 0; i < 16; i++) wbuf[i] = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Single write then single read
    wbuf[0] = 32'hDEADBEEF;
    run_cmd(1'b1, 32'h10, 3'd2, 5'd1);
    check("t1w_lat", lat, 3);
    check("t1w_err", got_err, 0);
    check("t1w_trans", tr_htrans[1], 2'b10);
    check("t1w_haddr", tr_haddr[1], 32'h10);
    check("t1w_hburst", tr_hburst[1], 3'b000);
    check("t1w_hsel", tr_hsel[1], 1'b1);
    check("t1w_wrready", tr_wrready[1], 1'b1);
    check("t1w_hwdata", tr_hwdata[2], 32'hDEADBEEF);
    check("t1w_idle", {tr_hsel[2], tr_htrans[2]}, 3'b000);
    run_cmd(1'b0, 32'h10, 3'd2, 5'd1);
    check("t1r_lat", lat, 3);
    check("t1r_err", got_err, 0);
    check("t1r_cnt", rd_cnt, 1);
    check("t1r_data", rd_buf[0], 32'hDEADBEEF);

    // INCR4 write and read back
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    run_cmd(1'b1, 32'h40, 3'd2, 5'd4);
    check("t2w_lat", lat, 6);
    check("t2w_err", got_err, 0);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("t2w_trans%0d", k), tr_htrans[k], (k == 1) ? 2'b10 : T_SEQ);
      check($sformatf("t2w_haddr%0d", k), tr_haddr[k], 32'h40 + 32'(4 * (k - 1)));
      check($sformatf("t2w_hburst%0d", k), tr_hburst[k], BURST ? 3'b011 : 3'b000);
    end
    check("t2w_lastdata", tr_hwdata[5], 32'd4);
    run_cmd(1'b0, 32'h40, 3'd2, 5'd4);
    check("t2r_lat", lat, 6);
    check("t2r_cnt", rd_cnt, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t2r_data%0d", i), rd_buf[i], 32'(i + 1));

    // INCR8 write with two wait states on beat 2
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h100 + 32'(i);
    wait_beat = 2;
    wait_len  = 2;
    run_cmd(1'b1, 32'h80, 3'd2, 5'd8);
    wait_beat = 0;
    check("t3w_lat", lat, 12);
    check("t3w_err", got_err, 0);
    for (int k = 3; k <= 5; k++) begin
      check($sformatf("t3w_haddr%0d", k), tr_haddr[k], 32'h88);
      check($sformatf("t3w_hwdata%0d", k), tr_hwdata[k], 32'h101);
      check($sformatf("t3w_trans%0d", k), tr_htrans[k], T_SEQ);
      check($sformatf("t3w_hready%0d", k), tr_hready[k], (k == 5));
    end
    run_cmd(1'b0, 32'h80, 3'd2, 5'd8);
    check("t3r_lat", lat, 10);
    check("t3r_cnt", rd_cnt, 8);
    for (int i = 0; i < 8; i++) check($sformatf("t3r_data%0d", i), rd_buf[i], 32'h100 + 32'(i));

    // INCR16 read with ERROR on beat 3
    err_beat = 3;
    run_cmd(1'b0, 32'h40, 3'd2, 5'd16);
    err_beat = 0;
    check("t4_lat", lat, 6);
    check("t4_err", got_err, 1);
    check("t4_rdcnt", rd_cnt, 2);
    check("t4_data0", rd_buf[0], 32'd1);
    check("t4_data1", rd_buf[1], 32'd2);
    check("t4_trans_err1", tr_htrans[4], T_SEQ);
    check("t4_trans_err2", tr_htrans[5], 2'b00);
    check("t4_hburst", tr_hburst[1], BURST ? 3'b111 : 3'b000);

    // Rejected commands
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    run_cmd(1'b1, 32'h3F8, 3'd2, 5'd4);
    check("t5_cross_lat", lat, BURST ? 1 : 6);
    check("t5_cross_err", got_err, BURST);
    check("t5_cross_trans", tr_htrans[1], BURST ? 2'b00 : 2'b10);
    check("t5_cross_hsel", tr_hsel[1], !BURST);
    run_cmd(1'b0, 32'h20, 3'd3, 5'd1);
    check("t5_size_lat", lat, 1);
    check("t5_size_err", got_err, 1);
    check("t5_size_trans", tr_htrans[1], 2'b00);
    run_cmd(1'b0, 32'h20, 3'd2, 5'd0);
    check("t5_len0_lat", lat, 1);
    check("t5_len0_err", got_err, 1);
    run_cmd(1'b0, 32'h12, 3'd2, 5'd1);
    check("t5_align_lat", lat, 1);
    check("t5_align_err", got_err, 1);

    // Reset in the middle of an INCR8 write, then a normal command
    wbeat = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h200;
    bus.cmd_size  = 3'd2;
    bus.cmd_len   = 5'd8;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_active", bus.HTRANS[1], 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset("t6_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(1'b0, 32'h10, 3'd2, 5'd1);
    check("t6_lat", lat, 3);
    check("t6_err", got_err, 0);
    check("t6_cnt", rd_cnt, 1);
    check("t6_data", rd_buf[0], 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
